axi_rd_arbiter: RTL and testbench
=================================

// Module: axi_rd_arbiter
// PURPOSE
// Round-robin arbiter multiplexing N burst-capable read masters (icache refill, dcache refill, uncached load)
// onto the single AXI read channel pair (AR/R) of the CPU bus interface. Master index is used as ARID.
// R beats are routed back by RID. Each master has at most one outstanding burst. Sits between the caches
// and the AXI port; write channels are not touched.
// PARAMETERS
// N_MST   3   number of read masters (1..8); ARID = master index, upper ARID bits zero
// MAX_LEN 16  maximum beats per burst; beat counter width = clog2(MAX_LEN)+1
// PORTS
// clk          in   1       clock
// resetn       in   1       synchronous active-low reset
// m_arvalid    in   N       per-master read request
// m_araddr     in   N*32    per-master address, slice [i*32+:32]
// m_arlen      in   N*8     per-master AXI len (beats-1), must be < MAX_LEN
// m_arsize     in   N*3     per-master AXI size
// m_arready    out  N       request accepted (one-cycle pulse)
// m_rdata      out  32      read data, shared by all masters
// m_rvalid     out  N       beat valid for master i
// m_rlast      out  N       last beat for master i
// m_rready     in   N       master i accepts beat
// arid/araddr/arlen/arsize/arvalid   out  4/32/8/3/1  AXI AR; arburst=INCR, arlock/arcache/arprot=0
// arready      in   1       AXI AR ready
// rid/rdata/rresp/rlast/rvalid       in   4/32/2/1/1   AXI R
// rready       out  1       AXI R ready
// err_proto    out  1       sticky: stray RID, or rlast vs beat count mismatch
// BEHAVIOUR
// - Reset (resetn=0 at posedge clk): all master states IDLE, AR stage empty, arvalid=0, rr pointer=0,
//   err_proto=0, beat counters=0. m_arready/m_rvalid are 0 while in reset. Reset mid-burst drops the burst;
//   the AXI slave shares resetn.
// - Per-master FSM: IDLE -> (granted) AR -> (arvalid&&arready) WAIT -> (rvalid&&rready&&rlast for this id) IDLE.
// - Arbitration: eligible = m_arvalid[i] && state[i]==IDLE. When the AR stage is empty, pick the first eligible
//   index at or after rr_ptr (wrapping). Latch addr/len/size/id into the AR stage, pulse m_arready[i], set
//   rr_ptr = grant+1 mod N_MST.
// - AR stage is a registered one-entry buffer: request at cycle t -> arvalid at t+1. Payload is held stable
//   until arready. The stage may refill in the same cycle it hands off (arvalid&&arready), giving one AR per cycle.
// - R routing (combinational):
//   - hit = rid<N_MST && state[rid]==WAIT.
//   - m_rvalid[rid] = rvalid && hit; m_rlast[rid] = rlast && hit; m_rdata = rdata.
//   - rready = hit ? m_rready[rid] : 1'b1. Stray beats are drained and set err_proto.
// - Beat counter per master: cleared on AR handshake, incremented per accepted beat.
//   - rlast on beat != len, or a beat past len without rlast -> set err_proto. The master still returns to IDLE on rlast.
// - rresp is ignored (forwarded nowhere); SLVERR handling belongs to the masters' owners.
// - Simultaneous events:
//   - A master completing its last beat becomes eligible the next cycle, not the same cycle.
//   - The AR handshake and a stray R beat in the same cycle are independent.
// - Masters must keep m_arvalid and payload stable until m_arready; deasserting early is allowed (request withdrawn).
// STRUCTURE
// - Shared package/header: AXI constants (BURST_INCR=2'b01, RESP_OKAY, RESP_SLVERR), state encodings
//   ST_IDLE/ST_AR/ST_WAIT, and the clog2 function.
// - One sub-module: rr_pick (N-bit request vector plus pointer -> one-hot grant plus valid). It is pure
//   combinational and reusable for the planned write-channel arbiter.
// TESTING
// 1. Single master 0 requests addr 0x1FC0_0000, len 7 with arready=1 -> arvalid at t+1, arid=0; 8 beats routed
//    to m_rvalid[0]; m_rlast[0] on beat 8; state IDLE after.
// 2. All three masters request the same cycle, rr_ptr=0 -> AR order ids 0,1,2 on consecutive accepted cycles;
//    re-request by 0 after completion is granted after 1 and 2.
// 3. arready held 0 for 5 cycles -> araddr/arlen/arid stable, no m_arready to other masters until handoff.
// 4. Interleaved R: ids 1 and 2 outstanding, slave returns beats 1,2,1,2 -> each beat reaches the right master;
//    m_rready[2]=0 stalls rready only for id-2 beats.
// 5. Stray rid=3 beat, and rlast on beat 3 of a len=7 burst -> rready=1 (drained), err_proto=1 and stays set
//    until reset.
// 6. resetn low during burst beat 4 -> next cycle arvalid=0, all m_* outputs 0, err_proto=0; a new request after
//    reset completes normally.

Source files
------------

// File: rtl/axi_rd_arbiter_pkg.sv
// Shared AXI read-arbiter definitions: AXI constants, master states, clog2.
package axi_rd_arbiter_pkg;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_WAIT = 2'd2
    } mst_state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/axi_rd_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after ptr (wrapping), one-hot out.
// Purely combinational so the write-channel arbiter can reuse it.
module axi_rd_arbiter_rr_pick #(
    parameter int N  = 3,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic          valid
);

    int idx;

    // scan N positions starting at ptr, keep the first hit
    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!valid && req[idx]) begin
                grant[idx] = 1'b1;
                valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Round-robin AXI read arbiter: N burst masters onto one AR/R pair, ARID = master index.
module axi_rd_arbiter
    import axi_rd_arbiter_pkg::*;
#(
    parameter int N_MST   = 3,
    parameter int MAX_LEN = 16
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [N_MST-1:0]   m_arvalid,
    input  logic [N_MST*32-1:0] m_araddr,
    input  logic [N_MST*8-1:0] m_arlen,
    input  logic [N_MST*3-1:0] m_arsize,
    output logic [N_MST-1:0]   m_arready,
    output logic [31:0]        m_rdata,
    output logic [N_MST-1:0]   m_rvalid,
    output logic [N_MST-1:0]   m_rlast,
    input  logic [N_MST-1:0]   m_rready,
    output logic [3:0]         arid,
    output logic [31:0]        araddr,
    output logic [7:0]         arlen,
    output logic [2:0]         arsize,
    output logic [1:0]         arburst,
    output logic               arlock,
    output logic [3:0]         arcache,
    output logic [2:0]         arprot,
    output logic               arvalid,
    input  logic               arready,
    input  logic [3:0]         rid,
    input  logic [31:0]        rdata,
    input  logic [1:0]         rresp,
    input  logic               rlast,
    input  logic               rvalid,
    output logic               rready,
    output logic               err_proto
);

    localparam int PTR_W = (N_MST > 1) ? clog2(N_MST) : 1;
    localparam int CNT_W = clog2(MAX_LEN) + 1;

    mst_state_e         state    [N_MST];
    mst_state_e         state_nx [N_MST];
    logic [CNT_W-1:0]   cnt      [N_MST];
    logic [7:0]         mst_len  [N_MST];
    logic [PTR_W-1:0]   rr_ptr;

    logic               ar_vld;
    logic [3:0]         ar_id;
    logic [31:0]        ar_addr;
    logic [7:0]         ar_len;
    logic [2:0]         ar_size;

    logic [N_MST-1:0]   elig, grant, hit_vec, beat_acc;
    logic               gvalid, take, ar_hs, hit, hit_rready, err_nx;
    logic [PTR_W-1:0]   gidx;
    logic [31:0]        sel_addr;
    logic [7:0]         sel_len;
    logic [2:0]         sel_size;

    // rresp is deliberately dropped; error responses are the masters' concern
    logic unused_rresp;
    assign unused_rresp = ^rresp;

    // a master may only compete when idle, so it has one burst in flight at most
    always_comb begin
        for (int i = 0; i < N_MST; i++)
            elig[i] = m_arvalid[i] && (state[i] == ST_IDLE);
    end

    axi_rd_arbiter_rr_pick #(.N(N_MST), .PW(PTR_W)) u_pick (
        .req   (elig),
        .ptr   (rr_ptr),
        .grant (grant),
        .valid (gvalid)
    );

    // stage accepts a new request when empty or handing off this cycle
    assign ar_hs = ar_vld && arready;
    assign take  = gvalid && (!ar_vld || arready);

    // one-hot grant to index plus payload mux
    always_comb begin
        gidx     = '0;
        sel_addr = '0;
        sel_len  = '0;
        sel_size = '0;
        for (int i = 0; i < N_MST; i++) begin
            if (grant[i]) begin
                gidx     = PTR_W'(i);
                sel_addr = m_araddr[i*32 +: 32];
                sel_len  = m_arlen[i*8 +: 8];
                sel_size = m_arsize[i*3 +: 3];
            end
        end
    end

    assign m_arready = (take && resetn) ? grant : '0;

    // AR stage register and round-robin pointer
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ar_vld  <= 1'b0;
            ar_id   <= '0;
            ar_addr <= '0;
            ar_len  <= '0;
            ar_size <= '0;
            rr_ptr  <= '0;
        end else if (take) begin
            ar_vld  <= 1'b1;
            ar_id   <= 4'(gidx);
            ar_addr <= sel_addr;
            ar_len  <= sel_len;
            ar_size <= sel_size;
            rr_ptr  <= (int'(gidx) == N_MST - 1) ? '0 : gidx + 1'b1;
        end else if (ar_hs) begin
            ar_vld  <= 1'b0;
        end
    end

    assign arvalid = ar_vld;
    assign arid    = ar_id;
    assign araddr  = ar_addr;
    assign arlen   = ar_len;
    assign arsize  = ar_size;
    assign arburst = BURST_INCR;
    assign arlock  = 1'b0;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;

    // route R by RID; beats for no waiting master are drained
    always_comb begin
        hit        = 1'b0;
        hit_rready = 1'b1;
        hit_vec    = '0;
        for (int i = 0; i < N_MST; i++) begin
            if (rid == 4'(i) && state[i] == ST_WAIT) begin
                hit_vec[i] = 1'b1;
                hit        = 1'b1;
                hit_rready = m_rready[i];
            end
        end
        rready   = hit ? hit_rready : 1'b1;
        beat_acc = (rvalid && rready) ? hit_vec : '0;
        m_rvalid = (rvalid && resetn) ? hit_vec : '0;
        m_rlast  = (rlast && rvalid && resetn) ? hit_vec : '0;
    end

    assign m_rdata = rdata;

    // per-master next state
    always_comb begin
        for (int i = 0; i < N_MST; i++) begin
            state_nx[i] = state[i];
            case (state[i])
                ST_IDLE: if (take && grant[i]) state_nx[i] = ST_AR;
                ST_AR:   if (ar_hs && ar_id == 4'(i)) state_nx[i] = ST_WAIT;
                ST_WAIT: if (beat_acc[i] && rlast) state_nx[i] = ST_IDLE;
                default: state_nx[i] = ST_IDLE;
            endcase
        end
    end

    // protocol check: stray beat, early rlast, or beat past len without rlast
    always_comb begin
        err_nx = rvalid && !hit;
        for (int i = 0; i < N_MST; i++) begin
            if (beat_acc[i]) begin
                if (rlast && 8'(cnt[i]) != mst_len[i]) err_nx = 1'b1;
                if (!rlast && 8'(cnt[i]) >= mst_len[i]) err_nx = 1'b1;
            end
        end
    end

    // state, beat counters, latched len, sticky error
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < N_MST; i++) begin
                state[i]   <= ST_IDLE;
                cnt[i]     <= '0;
                mst_len[i] <= '0;
            end
            err_proto <= 1'b0;
        end else begin
            for (int i = 0; i < N_MST; i++) begin
                state[i] <= state_nx[i];
                if (take && grant[i]) mst_len[i] <= sel_len;
                if (ar_hs && ar_id == 4'(i)) cnt[i] <= '0;
                else if (beat_acc[i] && cnt[i] != '1) cnt[i] <= cnt[i] + 1'b1;
            end
            if (err_nx) err_proto <= 1'b1;
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter with AR and per-master R scoreboards.
module tb_axi_rd_arbiter;
    import axi_rd_arbiter_pkg::*;

    localparam int N = 3;

    logic          clk = 1'b0;
    logic          resetn;
    logic [N-1:0]  m_arvalid;
    logic [N*32-1:0] m_araddr;
    logic [N*8-1:0] m_arlen;
    logic [N*3-1:0] m_arsize;
    logic [N-1:0]  m_arready;
    logic [31:0]   m_rdata;
    logic [N-1:0]  m_rvalid, m_rlast, m_rready;
    logic [3:0]    arid;
    logic [31:0]   araddr;
    logic [7:0]    arlen;
    logic [2:0]    arsize, arprot;
    logic [1:0]    arburst;
    logic          arlock;
    logic [3:0]    arcache;
    logic          arvalid, arready;
    logic [3:0]    rid;
    logic [31:0]   rdata;
    logic [1:0]    rresp;
    logic          rlast, rvalid, rready, err_proto;

    int checks = 0;
    int errors = 0;

    typedef struct { logic [3:0] id; logic [31:0] addr; logic [7:0] len; } ar_t;
    typedef struct { logic [31:0] d; logic l; } r_t;
    ar_t ar_q [$];
    r_t  r_q [N][$];

    always #5 clk = ~clk;

    axi_rd_arbiter #(.N_MST(N), .MAX_LEN(16)) dut (
        .clk(clk), .resetn(resetn),
        .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arready(m_arready), .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rlast(m_rlast),
        .m_rready(m_rready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .err_proto(err_proto)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic smp;
        @(negedge clk);
    endtask

    task automatic req(input int i, input logic [31:0] a, input logic [7:0] l);
        ar_t e;
        m_arvalid[i]        = 1'b1;
        m_araddr[i*32 +: 32] = a;
        m_arlen[i*8 +: 8]   = l;
        m_arsize[i*3 +: 3]  = 3'd2;
        e.id = 4'(i); e.addr = a; e.len = l;
        ar_q.push_back(e);
    endtask

    task automatic push_beat(input int i, input logic [31:0] d, input logic l);
        r_t e;
        e.d = d; e.l = l;
        r_q[i].push_back(e);
    endtask

    // one R beat held for exactly one cycle (caller ensures it is accepted)
    task automatic beat(input int i, input logic [31:0] d, input logic l);
        rid = 4'(i); rdata = d; rlast = l; rvalid = 1'b1;
        nxt;
        rvalid = 1'b0; rlast = 1'b0;
    endtask

    task automatic do_reset;
        resetn = 1'b0; m_arvalid = '0; rvalid = 1'b0; rlast = 1'b0;
        ar_q.delete();
        for (int i = 0; i < N; i++) r_q[i].delete();
        nxt;
        resetn = 1'b1;
    endtask

    // AR and R scoreboard monitor
    always @(negedge clk) begin
        ar_t ea;
        r_t  er;
        if (resetn && arvalid && arready) begin
            if (ar_q.size() == 0) chk("ar_unexpected", {60'd0, arid}, 64'hFF);
            else begin
                ea = ar_q.pop_front();
                chk("arid", arid, ea.id);
                chk("araddr", araddr, ea.addr);
                chk("arlen", arlen, ea.len);
                chk("arburst", arburst, 2'b01);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (m_rvalid[i] && m_rready[i]) begin
                if (r_q[i].size() == 0) chk("r_unexpected", i, 64'hFF);
                else begin
                    er = r_q[i].pop_front();
                    chk("m_rdata", m_rdata, er.d);
                    chk("m_rlast", m_rlast[i], er.l);
                end
            end
        end
    end

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; m_arvalid = '0; m_araddr = '0; m_arlen = '0; m_arsize = '0;
        m_rready = '1; arready = 1'b0; rid = '0; rdata = '0; rresp = RESP_OKAY;
        rlast = 1'b0; rvalid = 1'b0;

        // reset state
        nxt; nxt; smp;
        chk("rst_arvalid", arvalid, 1'b0);
        chk("rst_err", err_proto, 1'b0);
        chk("rst_m_arready", m_arready, 3'b000);
        chk("rst_m_rvalid", m_rvalid, 3'b000);
        nxt;
        resetn = 1'b1;

        // 1: single master, 8-beat burst
        arready = 1'b1;
        req(0, 32'h1FC0_0000, 8'd7);
        smp;
        chk("t1_m_arready", m_arready, 3'b001);
        chk("t1_arvalid_t", arvalid, 1'b0);
        nxt;
        m_arvalid = '0;
        smp;
        chk("t1_arvalid_t1", arvalid, 1'b1);
        nxt;
        smp;
        chk("t1_arvalid_done", arvalid, 1'b0);
        nxt;
        for (int b = 0; b < 8; b++) begin
            push_beat(0, 32'hA000 + 32'(b), b == 7);
            beat(0, 32'hA000 + 32'(b), b == 7);
        end
        smp;
        chk("t1_state_idle", dut.state[0], ST_IDLE);
        chk("t1_err", err_proto, 1'b0);
        nxt;

        // 2: all three request at once from rr_ptr=0
        do_reset;
        req(0, 32'h0000_1000, 8'd0);
        req(1, 32'h0000_2000, 8'd1);
        req(2, 32'h0000_3000, 8'd1);
        smp; chk("t2_grant0", m_arready, 3'b001); nxt;
        m_arvalid[0] = 1'b0;
        smp; chk("t2_grant1", m_arready, 3'b010); nxt;
        m_arvalid[1] = 1'b0;
        smp; chk("t2_grant2", m_arready, 3'b100); nxt;
        m_arvalid[2] = 1'b0;
        // master 0 finishes and re-requests in the same cycle: not yet eligible
        push_beat(0, 32'hB000, 1'b1);
        rid = 4'd0; rdata = 32'hB000; rlast = 1'b1; rvalid = 1'b1;
        req(0, 32'h0000_5000, 8'd0);
        smp; chk("t2_no_same_cycle", m_arready, 3'b000); nxt;
        rvalid = 1'b0; rlast = 1'b0;
        smp; chk("t2_regrant0", m_arready, 3'b001); nxt;
        m_arvalid = '0;

        // 4: interleaved R for ids 1 and 2, master 2 stalls once
        m_rready = 3'b011;
        push_beat(1, 32'hC100, 1'b0);
        rid = 4'd1; rdata = 32'hC100; rlast = 1'b0; rvalid = 1'b1;
        smp; chk("t4_rready_id1", rready, 1'b1); nxt;
        rid = 4'd2; rdata = 32'hC200;
        smp;
        chk("t4_rready_stall", rready, 1'b0);
        chk("t4_m_rvalid2", m_rvalid, 3'b100);
        nxt;
        m_rready = 3'b111;
        push_beat(2, 32'hC200, 1'b0);
        smp; chk("t4_rready_go", rready, 1'b1); nxt;
        push_beat(1, 32'hC101, 1'b1); beat(1, 32'hC101, 1'b1);
        push_beat(2, 32'hC201, 1'b1); beat(2, 32'hC201, 1'b1);
        push_beat(0, 32'hB100, 1'b1); beat(0, 32'hB100, 1'b1);
        smp;
        chk("t4_err", err_proto, 1'b0);
        chk("t4_idle1", dut.state[1], ST_IDLE);
        nxt;

        // 3: arready held low, stage must hold and block other grants
        arready = 1'b0;
        req(1, 32'h2000_0040, 8'd3);
        smp; chk("t3_grant1", m_arready, 3'b010); nxt;
        m_arvalid[1] = 1'b0;
        req(2, 32'h3000_0080, 8'd0);
        for (int c = 0; c < 5; c++) begin
            smp;
            chk("t3_arvalid", arvalid, 1'b1);
            chk("t3_araddr", araddr, 32'h2000_0040);
            chk("t3_arlen", arlen, 8'd3);
            chk("t3_arid", arid, 4'd1);
            chk("t3_no_grant", m_arready, 3'b000);
            nxt;
        end
        arready = 1'b1;
        smp; chk("t3_refill", m_arready, 3'b100); nxt;
        m_arvalid = '0;
        smp; chk("t3_arid2", arid, 4'd2); nxt;
        for (int b = 0; b < 4; b++) begin
            push_beat(1, 32'hD000 + 32'(b), b == 3);
            beat(1, 32'hD000 + 32'(b), b == 3);
        end
        push_beat(2, 32'hD200, 1'b1); beat(2, 32'hD200, 1'b1);

        // 5: stray RID drained and flagged
        smp; chk("t5_err_clear", err_proto, 1'b0); nxt;
        rid = 4'd3; rdata = 32'hDEAD; rlast = 1'b1; rvalid = 1'b1;
        smp;
        chk("t5_stray_rready", rready, 1'b1);
        chk("t5_stray_mrvalid", m_rvalid, 3'b000);
        nxt;
        rvalid = 1'b0; rlast = 1'b0;
        smp; chk("t5_err_stray", err_proto, 1'b1); nxt;
        // early rlast on beat 3 of len 7
        do_reset;
        smp; chk("t5_err_reset", err_proto, 1'b0); nxt;
        req(0, 32'h1FC0_0100, 8'd7);
        nxt; m_arvalid = '0; nxt; nxt;
        push_beat(0, 32'hE000, 1'b0); beat(0, 32'hE000, 1'b0);
        push_beat(0, 32'hE001, 1'b0); beat(0, 32'hE001, 1'b0);
        push_beat(0, 32'hE002, 1'b1); beat(0, 32'hE002, 1'b1);
        smp;
        chk("t5_err_early", err_proto, 1'b1);
        chk("t5_idle0", dut.state[0], ST_IDLE);
        nxt;
        repeat (3) nxt;
        smp; chk("t5_err_sticky", err_proto, 1'b1); nxt;

        // 6: reset in the middle of a burst
        do_reset;
        req(1, 32'h4000_0000, 8'd7);
        nxt; m_arvalid = '0; nxt; nxt;
        for (int b = 0; b < 3; b++) begin
            push_beat(1, 32'hF000 + 32'(b), 1'b0);
            beat(1, 32'hF000 + 32'(b), 1'b0);
        end
        rid = 4'd1; rdata = 32'hF003; rlast = 1'b0; rvalid = 1'b1; resetn = 1'b0;
        smp; chk("t6_rvalid_in_rst", m_rvalid, 3'b000); nxt;
        resetn = 1'b1; rvalid = 1'b0;
        smp;
        chk("t6_arvalid", arvalid, 1'b0);
        chk("t6_m_rvalid", m_rvalid, 3'b000);
        chk("t6_m_rlast", m_rlast, 3'b000);
        chk("t6_m_arready", m_arready, 3'b000);
        chk("t6_err", err_proto, 1'b0);
        chk("t6_idle1", dut.state[1], ST_IDLE);
        nxt;
        req(1, 32'h4000_0100, 8'd1);
        nxt; m_arvalid = '0; nxt; nxt;
        push_beat(1, 32'hF100, 1'b0); beat(1, 32'hF100, 1'b0);
        push_beat(1, 32'hF101, 1'b1); beat(1, 32'hF101, 1'b1);
        smp;
        chk("t6_idle_after", dut.state[1], ST_IDLE);
        chk("t6_err_after", err_proto, 1'b0);

        chk("ar_q_empty", ar_q.size(), 0);
        for (int i = 0; i < N; i++) chk("r_q_empty", r_q[i].size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
